// File: rtl/graph_search_sequencer.sv
// graph_search_sequencer: per-job controller that resets, arms and supervises the graph engine, then streams its path edges.
module graph_search_sequencer #(
  parameter int EDGE_NUM = 1034,
  parameter int POSE_NUM = 66,
  parameter int MAX_LEVEL = 10,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd200000,
  parameter int RST_HOLD = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [7:0]               req_start_pose,
  input  logic [7:0]               req_end_pose,
  input  logic [EDGE_NUM-1:0]      req_edge_mask,
  input  logic                     abort,
  output logic                     graph_rst_n,
  output logic [2:0]               graph_control,
  output logic [7:0]               graph_start_pose,
  output logic [7:0]               graph_end_pose,
  output logic [EDGE_NUM-1:0]      graph_edge_mask,
  input  logic [2:0]               graph_state,
  input  logic [10:0]              graph_ram_address,
  input  logic [MAX_LEVEL*11-1:0]  graph_select_edge,
  output logic                     edge_valid,
  input  logic                     edge_ready,
  output logic [10:0]              edge_index,
  output logic                     edge_last,
  output logic                     done_valid,
  output logic [2:0]               done_status,
  output logic [3:0]               done_len,
  output logic                     busy
);
  localparam logic [2:0] S_IDLE = 3'd0, S_RST = 3'd1, S_FARM = 3'd2, S_FRUN = 3'd3,
                         S_BARM = 3'd4, S_BRUN = 3'd5, S_STRM = 3'd6, S_DONE = 3'd7;
  localparam int BW = $clog2(MAX_LEVEL * 11);
  logic [2:0]               state;
  logic [31:0]              timer;
  logic [3:0]               level, len, ptr, d_len;
  logic [2:0]               d_status;
  logic [MAX_LEVEL*11-1:0]  sel;
  logic                     timed;
  logic [31:0]              timer_nx;
  logic [4:0]               len_raw;
  logic [BW-1:0]            base;
  assign timed    = state >= S_FARM && state <= S_BRUN;
  assign timer_nx = timer + 32'd1;
  assign len_raw  = {1'b0, level} + 5'd1;
  assign base     = BW'(ptr) * BW'(11);
  assign req_ready     = !RST && state == S_IDLE;
  assign busy          = state != S_IDLE;
  assign graph_rst_n   = !RST && state != S_RST && state != S_DONE;
  assign graph_control = state == S_FARM ? 3'b010 : state == S_BARM ? 3'b100 : 3'b000;
  assign edge_valid    = state == S_STRM;
  assign edge_index    = edge_valid ? sel[base +: 11] : 11'd0;
  assign edge_last     = edge_valid && ptr == len - 4'd1;
  assign done_valid    = state == S_DONE;
  assign done_status   = done_valid ? d_status : 3'd0;
  assign done_len      = done_valid ? d_len : 4'd0;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      timer <= '0;
      level <= '0;
      len <= '0;
      ptr <= '0;
      sel <= '0;
      d_status <= '0;
      d_len <= '0;
      graph_start_pose <= '0;
      graph_end_pose <= '0;
      graph_edge_mask <= '0;
    end else begin
      if (state == S_FRUN && graph_ram_address == 11'(EDGE_NUM) && level != 4'd15) level <= level + 4'd1;
      if (timed || state == S_RST) timer <= timer_nx;
      case (state)
        S_IDLE: if (req_valid) begin
          graph_start_pose <= req_start_pose;
          graph_end_pose <= req_end_pose;
          graph_edge_mask <= req_edge_mask;
          timer <= '0;
          level <= '0;
          if (req_start_pose >= 8'(POSE_NUM) || req_end_pose >= 8'(POSE_NUM)) begin
            state <= S_DONE;
            d_status <= 3'd3;
            d_len <= '0;
          end else if (req_start_pose == req_end_pose) begin
            state <= S_DONE;
            d_status <= 3'd0;
            d_len <= '0;
          end else state <= S_RST;
        end
        S_RST: if (timer == 32'(RST_HOLD - 1)) begin
          timer <= '0;
          state <= S_FARM;
        end
        S_FARM: if (graph_state == 3'd1) state <= S_FRUN;
        S_FRUN: if (graph_state == 3'd4) begin
          state <= S_DONE;
          d_status <= 3'd1;
          d_len <= '0;
        end else if (graph_state == 3'd2) state <= S_BARM;
        S_BARM: if (graph_state == 3'd3) state <= S_BRUN;
        S_BRUN: if (graph_state == 3'd4) begin
          state <= S_DONE;
          d_status <= 3'd1;
          d_len <= '0;
        end else if (graph_state == 3'd5) begin
          sel <= graph_select_edge;
          len <= len_raw > 5'(MAX_LEVEL) ? 4'(MAX_LEVEL) : len_raw[3:0];
          ptr <= '0;
          state <= S_STRM;
        end
        S_STRM: if (edge_ready) begin
          if (edge_last) begin
            state <= S_DONE;
            d_status <= 3'd0;
            d_len <= len;
          end else ptr <= ptr + 4'd1;
        end
        default: state <= S_IDLE;
      endcase
      // abort and the watchdog override whatever the engine reported this cycle
      if (abort && state != S_IDLE && state != S_DONE) begin
        state <= S_DONE;
        d_status <= 3'd4;
        d_len <= '0;
      end else if (timed && timer_nx == TIMEOUT_CYCLES) begin
        state <= S_DONE;
        d_status <= 3'd2;
        d_len <= '0;
      end
    end
  end
endmodule

// File: tb/tb_graph_search_sequencer.sv
// tb_graph_search_sequencer: random jobs against a behavioural engine and scoreboard, plus directed pins.
module tb_graph_search_sequencer;
  localparam int EN = 1034;
  localparam int SW = 110;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  logic req_valid = 0, req_ready, abort = 0, graph_rst_n, edge_valid, edge_ready = 0, edge_last;
  logic done_valid, busy;
  logic [7:0] req_start_pose = 0, req_end_pose = 0, graph_start_pose, graph_end_pose;
  logic [EN-1:0] req_edge_mask = '0, graph_edge_mask;
  logic [2:0] graph_control, graph_state = 0, done_status;
  logic [10:0] graph_ram_address = 0, edge_index;
  logic [SW-1:0] graph_select_edge = '0;
  logic [3:0] done_len;
  graph_search_sequencer #(.TIMEOUT_CYCLES(32'd50)) dut (
    .CLK(clk), .RST(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_start_pose(req_start_pose), .req_end_pose(req_end_pose), .req_edge_mask(req_edge_mask),
    .abort(abort), .graph_rst_n(graph_rst_n), .graph_control(graph_control),
    .graph_start_pose(graph_start_pose), .graph_end_pose(graph_end_pose),
    .graph_edge_mask(graph_edge_mask), .graph_state(graph_state),
    .graph_ram_address(graph_ram_address), .graph_select_edge(graph_select_edge),
    .edge_valid(edge_valid), .edge_ready(edge_ready), .edge_index(edge_index),
    .edge_last(edge_last), .done_valid(done_valid), .done_status(done_status),
    .done_len(done_len), .busy(busy));
  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc++;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", name, got, exp, cyc);
    end
  endtask
  function automatic int model_len(input int sweeps);
    return sweeps + 1 > 10 ? 10 : sweeps + 1;
  endfunction
  // behavioural engine: reacts to reset and control, sweeps RAM e_sweeps times, then finishes or fails
  int e_sweeps = 0, e_arm_delay = 1, es = 0, ecnt = 0;
  bit e_ffail = 0, e_bfail = 0, e_hang = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (!graph_rst_n) begin
      es = 0;
      ecnt = 0;
      graph_ram_address = 0;
    end else case (es)
      0: if (graph_control == 3'b010) begin
        ecnt++;
        if (ecnt >= e_arm_delay) begin es = 1; ecnt = 0; end
      end
      1: if (!e_hang) begin
        ecnt++;
        graph_ram_address = (ecnt % 2 == 0 && ecnt <= 2 * e_sweeps) ? 11'(EN) : 11'd0;
        if (ecnt == 2 * e_sweeps + 2) begin es = e_ffail ? 4 : 2; ecnt = 0; end
      end
      2: if (graph_control == 3'b100) begin es = 3; ecnt = 0; end
      3: begin
        ecnt++;
        if (ecnt == 3) es = e_bfail ? 4 : 5;
      end
      default: ;
    endcase
    graph_state = 3'(es);
  end
  bit ready_en = 0;
  initial forever begin
    @(posedge clk);
    #1;
    edge_ready = ready_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end
  logic [10:0] exp_q[$];
  logic [10:0] got_edges[$];
  logic [2:0] exp_status = 0;
  logic [3:0] exp_len = 0;
  logic [10:0] prev_idx = 0;
  bit prev_stall = 0, prev_done = 0, arm_seen = 0;
  int done_cnt = 0, last_done_cyc = 0, arm_cyc = 0, rst_low = 0, fwd_seen = 0, bwd_seen = 0, ev_cnt = 0;
  logic [3:0] last_len = 0;
  always @(negedge clk) if (!rst) begin
    check("ready_vs_busy", req_ready, !busy);
    if (edge_valid) ev_cnt++;
    if (edge_valid && prev_stall) check("index_stable", edge_index, prev_idx);
    if (edge_valid && edge_ready) begin
      got_edges.push_back(edge_index);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_edge got=%0h exp=none at cycle %0d", edge_index, cyc);
      end else begin
        check("edge_index", edge_index, exp_q.pop_front());
        check("edge_last", edge_last, exp_q.size() == 0);
      end
    end
    if (!graph_rst_n && !arm_seen) rst_low++;
    if (graph_control == 3'b010) begin
      fwd_seen++;
      if (!arm_seen) begin
        arm_seen = 1;
        arm_cyc = cyc;
        check("rst_hold", rst_low, 2);
      end
    end
    if (graph_control == 3'b100) bwd_seen++;
    if (done_valid) begin
      check("done_status", done_status, exp_status);
      check("done_len", done_len, exp_len);
      check("done_pulse", prev_done, 0);
      check("rst_n_in_done", graph_rst_n, 0);
      check("edges_left", exp_q.size(), 0);
      last_len = done_len;
      last_done_cyc = cyc;
      done_cnt++;
    end
    prev_done = done_valid;
    prev_stall = edge_valid && !edge_ready;
    prev_idx = edge_index;
  end
  task automatic present(input logic [7:0] sp, input logic [7:0] ep, input logic [EN-1:0] mask, output int acc);
    int n;
    @(posedge clk);
    #1;
    req_valid = 1;
    req_start_pose = sp;
    req_end_pose = ep;
    req_edge_mask = mask;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    if (n == 200) check("accept_bound", 0, 1);
    acc = cyc;
    @(posedge clk);
    #1;
    req_valid = 0;
    req_start_pose = 8'($urandom);
    req_end_pose = 8'($urandom);
    req_edge_mask = ~mask;
    rst_low = 0;
    arm_seen = 0;
    fwd_seen = 0;
    bwd_seen = 0;
    ev_cnt = 0;
    @(negedge clk);
    check("latched_start", graph_start_pose, sp);
    check("latched_end", graph_end_pose, ep);
    checks++;
    if (graph_edge_mask !== mask) begin
      failures++;
      $display("FAIL latched_mask differs from request at cycle %0d", cyc);
    end
  endtask
  // kinds: 0 ok, 1 fwd fail, 2 bwd fail, 3 bad pose, 4 same pose, 5 timeout, 6 abort early, 7 abort in stream
  task automatic run_job(input int kind, input logic [7:0] sp, input logic [7:0] ep, input int sweeps,
                         input logic [SW-1:0] sel, input logic [EN-1:0] mask);
    int acc, start, n, len;
    e_sweeps = sweeps;
    e_ffail = kind == 1;
    e_bfail = kind == 2;
    e_hang = kind == 5;
    e_arm_delay = $urandom_range(1, 3);
    graph_select_edge = sel;
    len = model_len(sweeps);
    exp_q.delete();
    got_edges.delete();
    exp_status = kind == 0 || kind == 4 ? 3'd0 : kind <= 2 ? 3'd1 : kind == 3 ? 3'd3 : kind == 5 ? 3'd2 : 3'd4;
    exp_len = kind == 0 ? 4'(len) : 4'd0;
    if (kind == 0) for (int i = 0; i < len; i++) exp_q.push_back(sel[i*11 +: 11]);
    ready_en = kind != 7;
    start = done_cnt;
    present(sp, ep, mask, acc);
    if (kind == 6) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      abort = 1;
      @(negedge clk);
      abort = 0;
    end
    if (kind == 7) begin
      for (n = 0; n < 300; n++) begin
        if (edge_valid) break;
        @(negedge clk);
      end
      if (n == 300) check("stream_bound", 0, 1);
      abort = 1;
      @(negedge clk);
      abort = 0;
    end
    for (n = 0; n < 3000; n++) begin
      @(posedge clk);
      if (done_cnt > start) break;
    end
    if (n == 3000) check("done_bound", 0, 1);
    if (kind == 3 || kind == 4) begin
      check("done_latency", last_done_cyc - acc, 1);
      check("no_engine", fwd_seen + bwd_seen, 0);
    end
    if (kind == 5) check("timeout_cycles", last_done_cyc - arm_cyc, 50);
    if (kind == 0 || kind == 2) check("bwd_armed", bwd_seen > 0, 1);
    if (kind == 1) check("no_bwd", bwd_seen, 0);
    if (kind >= 1 && kind <= 3) check("no_edge_valid", ev_cnt, 0);
    if (kind == 0) check("edge_count", got_edges.size(), len);
    if (kind == 7) begin
      #1;
      check("ready_after_abort", req_ready, 1);
    end
  endtask
  function automatic logic [SW-1:0] rand_sel();
    return SW'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction
  function automatic logic [EN-1:0] rand_mask();
    logic [EN-1:0] m;
    for (int i = 0; i < EN; i++) m[i] = 1'($urandom_range(0, 1));
    return m;
  endfunction
  initial begin
    logic [SW-1:0] s;
    logic [EN-1:0] m;
    int kind, start;
    logic [7:0] sp, ep;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_graph_rst_n", graph_rst_n, 0);
    check("rst_control", graph_control, 0);
    check("rst_busy", busy, 0);
    check("rst_edge_valid", edge_valid, 0);
    check("rst_done", {done_valid, done_status, done_len}, 0);
    check("rst_edge_index", edge_index, 0);
    check("rst_poses", {graph_start_pose, graph_end_pose}, 0);
    rst = 0;
    s = '0;
    s[10:0] = 11'd7;
    s[21:11] = 11'd4;
    s[32:22] = 11'd1;
    run_job(0, 8'd0, 8'd3, 2, s, '0);
    check("pin_len", last_len, 4'd3);
    check("pin_edge0", got_edges.size() > 0 ? got_edges[0] : 11'h7ff, 11'd7);
    check("pin_edge1", got_edges.size() > 1 ? got_edges[1] : 11'h7ff, 11'd4);
    check("pin_edge2", got_edges.size() > 2 ? got_edges[2] : 11'h7ff, 11'd1);
    m = '0;
    m[EN-1:EN-8] = 8'hff;
    run_job(1, 8'd0, 8'd3, 1, rand_sel(), m);
    run_job(3, 8'd1, 8'd70, 0, rand_sel(), '0);
    run_job(4, 8'd5, 8'd5, 0, rand_sel(), '0);
    run_job(5, 8'd2, 8'd9, 0, rand_sel(), '0);
    run_job(0, 8'd10, 8'd20, 17, rand_sel(), rand_mask());
    check("pin_len_clamp", last_len, 4'd10);
    run_job(7, 8'd4, 8'd8, 3, rand_sel(), '0);
    run_job(0, 8'd8, 8'd4, 9, rand_sel(), '0);
    check("pin_len_max", last_len, 4'd10);
    start = done_cnt;
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    @(negedge clk);
    check("idle_abort_busy", busy, 0);
    check("idle_abort_done", done_cnt, start);
    for (int j = 0; j < 30; j++) begin
      kind = $urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 7);
      sp = 8'($urandom_range(0, 65));
      ep = 8'((sp + $urandom_range(1, 65)) % 66);
      if (kind == 3) begin
        if ($urandom_range(0, 1) == 1) ep = 8'($urandom_range(66, 255));
        else sp = 8'($urandom_range(66, 255));
      end
      if (kind == 4) ep = sp;
      run_job(kind, sp, ep, $urandom_range(0, 14), rand_sel(), rand_mask());
    end
    start = done_cnt;
    e_ffail = 0;
    e_bfail = 0;
    e_hang = 0;
    present(8'd1, 8'd2, '0, kind);
    repeat (4) @(negedge clk);
    rst = 1;
    #1;
    check("midjob_rst_n", graph_rst_n, 0);
    @(negedge clk);
    check("midjob_busy", busy, 0);
    check("midjob_no_done", done_cnt, start);
    rst = 0;
    run_job(0, 8'd30, 8'd31, 4, rand_sel(), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end
endmodule

// File: doc/graph_search_sequencer.md
Name: graph_search_sequencer

Overview:
- Job-level controller for the flatten/graph search engine (`graph`).
- Accepts one path request (start pose, end pose, edge mask) per job, resets and arms the engine, and sequences it through its forward and backward phases. It also supervises the job with a timeout.
- On completion it streams the selected edges out one per handshake, then reports a status and path length.
- Sits between the planner (requester) and the `graph` instance; the edge RAM stays owned by the engine.

Parameters:
- EDGE_NUM, 1034, number of edges; engine RAM sweep wraps when its address equals this value.
- POSE_NUM, 66, number of valid poses; pose indices ≥ POSE_NUM are rejected.
- MAX_LEVEL, 10, number of selectEdge slots of 11 bits each.
- TIMEOUT_CYCLES, 32'd200000, job watchdog in CLK cycles, counted from the first arm cycle.
- RST_HOLD, 2, cycles `graph_rst_n` is held low before each job.

Ports:
- CLK  in  1  clock; engine runs on the same clock.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  high only in IDLE.
- req_start_pose  in  8  start pose.
- req_end_pose  in  8  end pose.
- req_edge_mask  in  1034  1 = edge blocked.
- abort  in  1  cancel the current job.
- graph_rst_n  out  1  engine reset, active low.
- graph_control  out  3  engine control: 3'b010 = go forward, 3'b100 = go backward, else 0.
- graph_start_pose  out  8  registered copy of the request.
- graph_end_pose  out  8  registered copy of the request.
- graph_edge_mask  out  1034  registered copy of the request.
- graph_state  in  3  engine state: 0 FWD_INIT, 1 FWD_WORK, 2 BWD_INIT, 3 BWD_WORK, 4 FAIL, 5 FINISH.
- graph_ram_address  in  11  engine RAM address.
- graph_select_edge  in  110  engine selected-edge slots.
- edge_valid  out  1  path edge available.
- edge_ready  in  1  consumer accepts the edge.
- edge_index  out  11  edge number.
- edge_last  out  1  final edge of the path.
- done_valid  out  1  one-cycle completion pulse.
- done_status  out  3  0 OK, 1 NO_PATH, 2 TIMEOUT, 3 BAD_POSE, 4 ABORTED.
- done_len  out  4  number of edges streamed.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (RST=1 at a CLK edge):
  - state IDLE; graph_rst_n=0, graph_control=0, all other outputs 0.
  - Internal level count, timer and slot pointer cleared.
- IDLE:
  - req_ready=1, graph_rst_n=1.
  - On req_valid: latch pose and mask into the graph_* registers, clear timer and level count.
  - Start or end pose ≥ POSE_NUM → DONE with BAD_POSE, len 0.
  - start == end → DONE with OK, len 0, engine not run.
  - Otherwise → ENG_RST.
- ENG_RST: graph_rst_n=0 for RST_HOLD cycles, then → FWD_ARM.
- FWD_ARM: graph_control=3'b010 until graph_state==1 is sampled, then control=0 → FWD_RUN.
- FWD_RUN:
  - Increment the level count on every cycle with graph_ram_address==EDGE_NUM (saturating at 15).
  - graph_state==4 → DONE with NO_PATH.
  - graph_state==2 → BWD_ARM.
- BWD_ARM: graph_control=3'b100 until graph_state==3, then 0 → BWD_RUN.
- BWD_RUN:
  - On graph_state==5: latch graph_select_edge and set path length = level count + 1 (clamped to MAX_LEVEL) → STREAM.
  - graph_state==4 → DONE with NO_PATH.
- STREAM:
  - Drive slot p (p from 0): edge_index = bits [p*11 +: 11]; edge_last = (p == len-1).
  - edge_valid stays high, with index stable, until edge_ready. p advances on each valid&&ready.
  - After the last edge is accepted → DONE with OK.
  - Edges emerge in end→start order (slot 0 touches end pose).
- DONE: done_valid=1 for exactly one cycle with status and len, graph_rst_n=0, then → IDLE. busy drops in the IDLE cycle.
- Timeout:
  - Timer counts every cycle in FWD_ARM through BWD_RUN.
  - When it reaches TIMEOUT_CYCLES → DONE with TIMEOUT, len 0.
  - Not active in STREAM (consumer backpressure is unbounded).
- Abort:
  - In any non-IDLE, non-DONE state → DONE with ABORTED, len 0; no further edges are streamed.
  - Abort in IDLE is ignored.
- Priority in one cycle: RST > abort > timeout > engine FAIL > engine progress.
- A request presented while busy is not accepted: req_ready=0, and the requester holds req_valid.
- Reset mid-job: immediate return to IDLE with graph_rst_n low that cycle; no done pulse.

Test Plan:
- req start=0, end=3, chain 0-1-2-3 unmasked → graph_rst_n low 2 cycles, control 010 then 100.
  - Stream of 3 edges, slot order, edge_last on the 3rd.
  - done status 0, len 3.
- end pose isolated by mask → engine FAIL; done status 1, len 0; edge_valid never asserted.
- req_end_pose=70 → done status 3 the cycle after acceptance; graph_rst_n never released.
- start=end=5 → done status 0, len 0; graph_control stays 0.
- TIMEOUT_CYCLES=50, engine held in FWD_WORK → done status 2 at cycle 50 after the first arm cycle.
- Abort while edge_ready=0 during STREAM → done status 4, then a new request accepted in the following IDLE.
